// File: rtl/msdap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : msdap_pkg
// Description : Shared constants, state encoding and helpers for the MSDAP
//               loading stage (rj memory + coefficient memory front end).
// Revision    : 1.0 - initial release
// ============================================================================
package msdap_pkg;

    // Default word geometry of the serial stream and the two memories
    localparam int c_DW          = 16;
    localparam int c_RJ_WORDS    = 16;
    localparam int c_COEFF_WORDS = 512;

    // Memory address widths
    localparam int c_RJ_AW    = 4;
    localparam int c_COEFF_AW = 9;

    // Width of the saturating frame error counter
    localparam int c_ERR_CW = 8;

    // Loader FSM encoding (0..4), kept as plain constants for legacy tools
    typedef logic [2:0] state_t;

    localparam state_t c_WAIT_RJ    = 3'd0;
    localparam state_t c_LOAD_RJ    = 3'd1;
    localparam state_t c_WAIT_COEFF = 3'd2;
    localparam state_t c_LOAD_COEFF = 3'd3;
    localparam state_t c_DONE       = 3'd4;

    // True in the two states that accept serial words for writing
    function automatic logic is_load_state(input state_t s);
        return (s == c_LOAD_RJ) || (s == c_LOAD_COEFF);
    endfunction

    // True in the two states that idle until the next Frame
    function automatic logic is_wait_state(input state_t s);
        return (s == c_WAIT_RJ) || (s == c_WAIT_COEFF);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rj_coeff_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : rj_coeff_loader_if
// Description : Serial input stream and memory write bus of the rj/coefficient
//               loader. Optional macro LOADER_FRAME_ERR_EN adds the frame
//               error pulse and error counter signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface rj_coeff_loader_if
    import msdap_pkg::*;
#(
    parameter int DW = c_DW
);

    // Serial stream and control from upstream
    logic                  Frame;
    logic                  InputL;
    logic                  reload;

    // Memory write side and status
    logic                  rj_we;
    logic [c_RJ_AW-1:0]    rj_addr;
    logic                  coeff_we;
    logic [c_COEFF_AW-1:0] coeff_addr;
    logic [DW-1:0]         wr_data;
    logic                  load_done;
    logic [2:0]            state_o;

`ifdef LOADER_FRAME_ERR_EN
    logic                  frame_err;
    logic [c_ERR_CW-1:0]   err_cnt;

    // Stream source / status consumer
    modport master (
        output Frame, InputL, reload,
        input  rj_we, rj_addr, coeff_we, coeff_addr, wr_data,
        input  load_done, state_o, frame_err, err_cnt
    );

    // Loader side
    modport slave (
        input  Frame, InputL, reload,
        output rj_we, rj_addr, coeff_we, coeff_addr, wr_data,
        output load_done, state_o, frame_err, err_cnt
    );
`else
    // Stream source / status consumer
    modport master (
        output Frame, InputL, reload,
        input  rj_we, rj_addr, coeff_we, coeff_addr, wr_data,
        input  load_done, state_o
    );

    // Loader side
    modport slave (
        input  Frame, InputL, reload,
        output rj_we, rj_addr, coeff_we, coeff_addr, wr_data,
        output load_done, state_o
    );
`endif

endinterface
`default_nettype wire

// File: rtl/rj_coeff_loader_deser.sv
`default_nettype none
// ============================================================================
// Module      : serial_deserializer
// Description : MSB-first serial to parallel converter with Frame resync.
//               Reports a completed word while the bit counter sits on the
//               last bit, and flags a Frame that arrives mid-word.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_deserializer
    import msdap_pkg::*;
#(
    parameter int DW = c_DW
) (
    input  wire logic          Sclk,
    input  wire logic          Reset_n,
    input  wire logic          Frame,
    input  wire logic          InputL,
    input  wire logic          enable,
    output logic [DW-1:0]      word,
    output logic               word_valid,
    output logic               frame_err_raw
);

    localparam int                c_CW   = $clog2(DW);
    localparam logic [c_CW-1:0]   c_LAST = c_CW'(DW - 1);

    logic [DW-1:0]   r_shift;
    logic [c_CW-1:0] r_bit_cnt;

    // Shift in one bit per edge; Frame marks the MSB and restarts the count
    always_ff @(posedge Sclk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (enable) begin
            r_shift <= {r_shift[DW-2:0], InputL};
            if (Frame) begin
                r_bit_cnt <= '0;
            end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    // The LSB landed on the previous edge when the counter reads the last bit
    assign word          = r_shift;
    assign word_valid    = enable && (r_bit_cnt == c_LAST);
    assign frame_err_raw = enable && Frame && (r_bit_cnt != c_LAST);

endmodule
`default_nettype wire

// File: rtl/rj_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module      : rj_coeff_loader
// Description : Loading-phase sequencer of the MSDAP datapath. Deserialises
//               the framed serial stream, writes RJ_WORDS words into the rj
//               memory, then COEFF_WORDS words into the coefficient memory,
//               and raises load_done once both are full.
//               Optional macro LOADER_FRAME_ERR_EN adds frame_err / err_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module rj_coeff_loader
    import msdap_pkg::*;
#(
    parameter int DW          = c_DW,
    parameter int RJ_WORDS    = c_RJ_WORDS,
    parameter int COEFF_WORDS = c_COEFF_WORDS
) (
    input  wire logic        Sclk,
    input  wire logic        Reset_n,
    rj_coeff_loader_if.slave bus
);

    localparam logic [c_COEFF_AW-1:0] c_RJ_LAST    = c_COEFF_AW'(RJ_WORDS - 1);
    localparam logic [c_COEFF_AW-1:0] c_COEFF_LAST = c_COEFF_AW'(COEFF_WORDS - 1);

    state_t                r_state;
    logic [c_COEFF_AW-1:0] r_word_cnt;
    logic                  r_rj_we;
    logic [c_RJ_AW-1:0]    r_rj_addr;
    logic                  r_coeff_we;
    logic [c_COEFF_AW-1:0] r_coeff_addr;
    logic [DW-1:0]         r_wr_data;
    logic                  r_load_done;

    logic [DW-1:0]         w_word;
    logic                  w_word_valid;
    logic                  w_frame_err_raw;
    logic                  w_in_load;
    logic                  w_enable;

    // Shifting runs through the load states, and in a wait state only on the
    // Frame edge that starts loading so that edge captures the MSB
    always_comb begin
        w_in_load = is_load_state(r_state);
        w_enable  = w_in_load || (is_wait_state(r_state) && bus.Frame);
    end

    serial_deserializer #(
        .DW (DW)
    ) u_deser (
        .Sclk          (Sclk),
        .Reset_n       (Reset_n),
        .Frame         (bus.Frame),
        .InputL        (bus.InputL),
        .enable        (w_enable),
        .word          (w_word),
        .word_valid    (w_word_valid),
        .frame_err_raw (w_frame_err_raw)
    );

    // Loading sequencer: one registered write strobe per completed word;
    // reload has priority over everything, including a pending write
    always_ff @(posedge Sclk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= c_WAIT_RJ;
            r_word_cnt   <= '0;
            r_rj_we      <= 1'b0;
            r_rj_addr    <= '0;
            r_coeff_we   <= 1'b0;
            r_coeff_addr <= '0;
            r_wr_data    <= '0;
            r_load_done  <= 1'b0;
        end else begin
            r_rj_we    <= 1'b0;
            r_coeff_we <= 1'b0;
            if (bus.reload) begin
                r_state     <= c_WAIT_RJ;
                r_word_cnt  <= '0;
                r_load_done <= 1'b0;
            end else begin
                r_load_done <= (r_state == c_DONE);
                case (r_state)
                    c_WAIT_RJ: begin
                        if (bus.Frame) begin
                            r_state    <= c_LOAD_RJ;
                            r_word_cnt <= '0;
                        end
                    end
                    c_LOAD_RJ: begin
                        if (w_word_valid) begin
                            r_rj_we   <= 1'b1;
                            r_rj_addr <= r_word_cnt[c_RJ_AW-1:0];
                            r_wr_data <= w_word;
                            if (r_word_cnt == c_RJ_LAST) begin
                                r_state    <= c_WAIT_COEFF;
                                r_word_cnt <= '0;
                            end else begin
                                r_word_cnt <= r_word_cnt + 1'b1;
                            end
                        end
                    end
                    c_WAIT_COEFF: begin
                        if (bus.Frame) begin
                            r_state    <= c_LOAD_COEFF;
                            r_word_cnt <= '0;
                        end
                    end
                    c_LOAD_COEFF: begin
                        if (w_word_valid) begin
                            r_coeff_we   <= 1'b1;
                            r_coeff_addr <= r_word_cnt;
                            r_wr_data    <= w_word;
                            if (r_word_cnt == c_COEFF_LAST) begin
                                r_state    <= c_DONE;
                                r_word_cnt <= '0;
                            end else begin
                                r_word_cnt <= r_word_cnt + 1'b1;
                            end
                        end
                    end
                    c_DONE: begin
                        r_state <= c_DONE;
                    end
                    default: begin
                        r_state    <= c_WAIT_RJ;
                        r_word_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.rj_we      = r_rj_we;
    assign bus.rj_addr    = r_rj_addr;
    assign bus.coeff_we   = r_coeff_we;
    assign bus.coeff_addr = r_coeff_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.load_done  = r_load_done;
    assign bus.state_o    = r_state;

`ifdef LOADER_FRAME_ERR_EN
    logic                r_frame_err;
    logic [c_ERR_CW-1:0] r_err_cnt;

    // Pulse and count each mid-word resync seen while loading
    always_ff @(posedge Sclk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_frame_err <= 1'b0;
            r_err_cnt   <= '0;
        end else if (bus.reload) begin
            r_frame_err <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_frame_err <= w_in_load && w_frame_err_raw;
            if (w_in_load && w_frame_err_raw && (r_err_cnt != {c_ERR_CW{1'b1}})) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign bus.frame_err = r_frame_err;
    assign bus.err_cnt   = r_err_cnt;
`else
    logic w_unused_frame_err;
    assign w_unused_frame_err = w_frame_err_raw;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rj_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_rj_coeff_loader
// Description : Directed self-checking bench for rj_coeff_loader. A
//               word-level model predicts every write strobe and load_done;
//               directed literal checks pin the model at key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rj_coeff_loader;

    logic Sclk = 1'b0;
    logic Reset_n;

    rj_coeff_loader_if #(.DW(16)) bus ();

    rj_coeff_loader #(
        .DW          (16),
        .RJ_WORDS    (16),
        .COEFF_WORDS (512)
    ) dut (
        .Sclk    (Sclk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Sclk = ~Sclk;

    typedef struct {
        int          edge_n;
        bit          coeff;
        int          addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          cyc       = 0;
    int          n_vec     = 0;
    int          n_fail    = 0;
    int          phase     = 0;   // 0 wait rj, 1 rj, 2 wait coeff, 3 coeff, 4 done
    int          cnt       = 0;
    int          done_w    = -1;
    int          n_rj      = 0;
    int          n_co      = 0;
    int          n_ferr    = 0;
    int          last_addr = -1;
    logic [15:0] last_data = '0;

    always @(posedge Sclk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-edge comparison against the word-level model
    always @(posedge Sclk) begin : p_cmp
        wr_t cur;
        #1;
        while (exp_q.size() > 0 && exp_q[0].edge_n < cyc) begin
            check("write_missed", 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].edge_n == cyc) begin
            cur = exp_q.pop_front();
            check("rj_we", bus.rj_we, !cur.coeff);
            check("coeff_we", bus.coeff_we, cur.coeff);
            if (cur.coeff) check("coeff_addr", bus.coeff_addr, cur.addr);
            else           check("rj_addr", bus.rj_addr, cur.addr);
            check("wr_data", bus.wr_data, cur.data);
        end else begin
            check("rj_we_idle", bus.rj_we, 32'd0);
            check("coeff_we_idle", bus.coeff_we, 32'd0);
        end
        check("load_done", bus.load_done, (done_w >= 0 && cyc >= done_w + 1));
        if (bus.rj_we === 1'b1) begin
            n_rj++;
            last_addr = bus.rj_addr;
            last_data = bus.wr_data;
        end
        if (bus.coeff_we === 1'b1) n_co++;
`ifdef LOADER_FRAME_ERR_EN
        if (bus.frame_err === 1'b1) n_ferr++;
`endif
    end

    task automatic model_reload();
        exp_q.delete();
        phase  = 0;
        cnt    = 0;
        done_w = -1;
    endtask

    // Drive one bit for the next rising edge; e is that edge's index
    task automatic drive(input logic f, input logic b, input logic rl, output int e);
        @(negedge Sclk);
        bus.Frame  = f;
        bus.InputL = b;
        bus.reload = rl;
        e = cyc + 1;
    endtask

    task automatic idle(input int n);
        int e;
        for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom % 2), 1'b0, e);
    endtask

    // Send nbits of a framed word, optionally pulsing reload on bit rl_bit
    task automatic send_word(input logic [15:0] w, input int nbits, input int rl_bit);
        int e;
        bit aborted;
        aborted = 0;
        e = 0;
        for (int i = 0; i < nbits; i++) begin
            drive(i == 0, w[15-i], i == rl_bit, e);
            if (i == 0) begin
                if (phase == 0) begin phase = 1; cnt = 0; end
                else if (phase == 2) begin phase = 3; cnt = 0; end
            end
            if (i == rl_bit) begin
                model_reload();
                aborted = 1;
            end
        end
        if (nbits == 16 && !aborted && (phase == 1 || phase == 3)) begin
            exp_q.push_back('{edge_n: e + 1, coeff: (phase == 3), addr: cnt, data: w});
            cnt++;
            if (phase == 1 && cnt == 16) begin
                phase = 2;
            end else if (phase == 3 && cnt == 512) begin
                phase  = 4;
                done_w = e + 1;
            end
        end
    endtask

    task automatic pulse_reload();
        int e;
        drive(1'b0, 1'b0, 1'b1, e);
        model_reload();
    endtask

    initial begin
        int base;
        Reset_n    = 1'b0;
        bus.Frame  = 1'b0;
        bus.InputL = 1'b0;
        bus.reload = 1'b0;
        repeat (3) @(negedge Sclk);
        check("rst_state", bus.state_o, 32'd0);
        check("rst_wr_data", bus.wr_data, 32'd0);
        check("rst_load_done", bus.load_done, 32'd0);
        Reset_n = 1'b1;

        // Idle random bits in WAIT_RJ
        idle(100);
        check("idle_wait_rj_state", bus.state_o, 32'd0);
        check("idle_wait_rj_pulses", n_rj, 32'd0);

        // Full rj load
        for (int i = 0; i < 16; i++) send_word(16'(i + 1), 16, -1);
        idle(2);
        check("rj_pulses", n_rj, 32'd16);
        check("rj_last_addr", last_addr, 32'd15);
        check("rj_last_data", last_data, 32'h0010);
        check("wait_coeff_state", bus.state_o, 32'd2);

        // Idle random bits in WAIT_COEFF
        idle(100);
        check("idle_wait_coeff_state", bus.state_o, 32'd2);
        check("idle_wait_coeff_pulses", n_co, 32'd0);

        // Full coefficient load, then frames in DONE
        for (int i = 0; i < 512; i++) send_word(16'(16'h8000 + i), 16, -1);
        idle(3);
        check("coeff_pulses", n_co, 32'd512);
        check("done_state", bus.state_o, 32'd4);
        check("done_load_done", bus.load_done, 32'd1);
        for (int i = 0; i < 3; i++) send_word(16'h5A5A, 16, -1);
        idle(2);
        check("done_no_strobes", n_co, 32'd512);

        // Reload from DONE, then mid-word Frame on rj word 3
        pulse_reload();
        idle(1);
        check("reload_state", bus.state_o, 32'd0);
        check("reload_load_done", bus.load_done, 32'd0);
        base = n_rj;
        for (int i = 0; i < 3; i++) send_word(16'(i + 1), 16, -1);
        send_word(16'h5555, 7, -1);
        send_word(16'hABCD, 16, -1);
        idle(2);
        check("resync_pulses", n_rj - base, 32'd4);
        check("resync_addr", last_addr, 32'd3);
        check("resync_data", last_data, 32'hABCD);
`ifdef LOADER_FRAME_ERR_EN
        check("frame_err_pulses", n_ferr, 32'd1);
        check("err_cnt", bus.err_cnt, 32'd1);
`endif

        // Finish rj, then reload during coeff word 100
        for (int i = 4; i < 16; i++) send_word(16'(16'h0100 + i), 16, -1);
        idle(1);
        base = n_co;
        for (int i = 0; i < 100; i++) send_word(16'(16'h8000 + i), 16, -1);
        send_word(16'h8064, 16, 5);
        idle(3);
        check("reload_coeff_pulses", n_co - base, 32'd100);
        check("reload_coeff_state", bus.state_o, 32'd0);
`ifdef LOADER_FRAME_ERR_EN
        check("reload_err_cnt", bus.err_cnt, 32'd0);
`endif
        send_word(16'h7777, 16, -1);
        idle(2);
        check("after_reload_addr", last_addr, 32'd0);
        check("after_reload_data", last_data, 32'h7777);

        // Reload coincident with a pending write
        base = n_rj;
        send_word(16'h1234, 16, -1);
        pulse_reload();
        idle(2);
        check("pending_suppressed", n_rj - base, 32'd0);
        send_word(16'h4321, 16, -1);
        idle(2);
        check("pending_next_addr", last_addr, 32'd0);

        // Async reset mid rj word 5
        for (int i = 1; i < 5; i++) send_word(16'(16'h0200 + i), 16, -1);
        send_word(16'h0205, 6, -1);
        @(negedge Sclk);
        Reset_n    = 1'b0;
        bus.Frame  = 1'b0;
        bus.reload = 1'b0;
        model_reload();
        #1;
        check("arst_rj_we", bus.rj_we, 32'd0);
        check("arst_coeff_we", bus.coeff_we, 32'd0);
        check("arst_rj_addr", bus.rj_addr, 32'd0);
        check("arst_coeff_addr", bus.coeff_addr, 32'd0);
        check("arst_wr_data", bus.wr_data, 32'd0);
        check("arst_load_done", bus.load_done, 32'd0);
        check("arst_state", bus.state_o, 32'd0);
        @(negedge Sclk);
        Reset_n = 1'b1;
        send_word(16'h00A5, 16, -1);
        idle(2);
        check("post_rst_addr", last_addr, 32'd0);
        check("post_rst_data", last_data, 32'h00A5);
        check("post_rst_state", bus.state_o, 32'd1);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
